// File: rtl/sfu_rsp_arbiter.sv
// Round-robin response arbiter: merges sub-unit commit responses into one
// stream buffered by a small registered FIFO ahead of the gather stage.
module sfu_rsp_arbiter #(
    parameter  int NUM_INPUTS = 2,
    parameter  int DATAW      = 64,
    parameter  int DEPTH      = 2,
    localparam int IDXW       = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_INPUTS-1:0]       valid_in,
    output logic [NUM_INPUTS-1:0]       ready_in,
    input  logic [NUM_INPUTS*DATAW-1:0] data_in,
    output logic                        valid_out,
    input  logic                        ready_out,
    output logic [DATAW-1:0]            data_out,
    output logic [IDXW-1:0]             sel_out
);
    localparam int PTRW = $clog2(DEPTH);
    localparam int CNTW = PTRW + 1;
    localparam logic [CNTW-1:0] FULL_CNT = CNTW'(DEPTH);

    logic [IDXW-1:0]  rr_ptr_q, rr_ptr_d;
    logic [PTRW-1:0]  rd_ptr_q, wr_ptr_q;
    logic [CNTW-1:0]  count_q, count_d;
    logic [DATAW-1:0] mem_data_q [DEPTH];
    logic [IDXW-1:0]  mem_sel_q  [DEPTH];

    logic             full, empty, found, push, pop;
    logic [IDXW-1:0]  grant_idx;
    logic [DATAW-1:0] grant_data;

    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);

    // Scan starts at rr_ptr and wraps; the first valid input wins.
    always_comb begin
        int unsigned cand;
        cand      = '0;
        found     = 1'b0;
        grant_idx = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            cand = (32'(rr_ptr_q) + 32'(i)) % 32'(NUM_INPUTS);
            for (int j = 0; j < NUM_INPUTS; j++) begin
                if (!found && valid_in[j] && cand == 32'(j)) begin
                    found     = 1'b1;
                    grant_idx = IDXW'(j);
                end
            end
        end
    end

    always_comb begin
        grant_data = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            if (grant_idx == IDXW'(i)) begin
                grant_data = data_in[i*DATAW +: DATAW];
            end
        end
    end

    // Accept is gated only by the registered full flag, never by ready_out.
    assign push     = found && !full && !reset;
    assign ready_in = push ? (NUM_INPUTS'(1) << grant_idx) : '0;
    assign pop      = valid_out && ready_out;

    always_comb begin
        int unsigned nxt;
        nxt      = (32'(grant_idx) + 32'd1) % 32'(NUM_INPUTS);
        rr_ptr_d = rr_ptr_q;
        if (push) begin
            rr_ptr_d = IDXW'(nxt);
        end
    end

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr_q <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            count_q  <= count_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_data_q[wr_ptr_q] <= grant_data;
            mem_sel_q[wr_ptr_q]  <= grant_idx;
        end
    end

    assign valid_out = !empty;
    assign data_out  = mem_data_q[rd_ptr_q];
    assign sel_out   = mem_sel_q[rd_ptr_q];

endmodule

// File: doc/sfu_rsp_arbiter.md
# sfu_rsp_arbiter

Round-robin response scheduler for the SFU. It merges commit responses from the SFU sub-units (warp-control unit, CSR unit, and any future sub-unit) into one buffered commit stream ahead of the gather stage. It guarantees starvation-free sharing of that stream through a rotating priority pointer. A small registered output FIFO decouples the sub-units' ready from downstream backpressure.

## Interface
- NUM_INPUTS, 2, number of requesting sub-units (1..8)
- DATAW, 64, payload width (commit data bundle)
- DEPTH, 2, output FIFO entries (power of two, 2..8)
- IDXW (local), max(1, clog2(NUM_INPUTS)), index width
- clk  in  1  clock; all state updates on posedge
- reset  in  1  asynchronous, active-high
- valid_in  in  NUM_INPUTS  per-input response valid
- ready_in  out  NUM_INPUTS  per-input accept (one-hot or zero)
- data_in  in  NUM_INPUTS*DATAW  per-input payload, input i at [i*DATAW +: DATAW]
- valid_out  out  1  head entry valid
- ready_out  in  1  downstream accept
- data_out  out  DATAW  head payload
- sel_out  out  IDXW  input index that produced the head entry

## Operation
- State: rr_ptr (IDXW), FIFO storage (DEPTH × (DATAW+IDXW)), rd_ptr/wr_ptr (clog2(DEPTH)), count (clog2(DEPTH)+1).
- full = (count == DEPTH); empty = (count == 0).
- Grant is combinational. Scan inputs rr_ptr, rr_ptr+1, … mod NUM_INPUTS. The first asserted valid_in wins.
- ready_in[g] = 1 only for the winner g, and only when !full and not in reset. All other ready_in bits are 0. ready_in never depends on ready_out: there is no combinational path from ready_out to ready_in.
- Push = valid_in[g] && ready_in[g]. On push, write {g, data_in[g]} at wr_ptr, increment wr_ptr (wraps mod DEPTH), and set rr_ptr = (g+1) mod NUM_INPUTS.
- rr_ptr is unchanged when nothing is pushed. An idle input does not move priority.
- Pop = valid_out && ready_out. On pop, increment rd_ptr (wraps mod DEPTH).
- count: push only → +1; pop only → −1; push and pop together → unchanged.
- Full with a pop in the same cycle: no push that cycle, because ready_in is derived from the registered full. The freed slot is usable the next cycle.
- valid_out = !empty. data_out and sel_out come from the entry at rd_ptr. Their values are don't-care while valid_out = 0.
- Payload and index pass through unmodified. Entries leave in push order.
- NUM_INPUTS = 1 degenerates to a FIFO with sel_out = 0.

## Timing
- Reset values: rr_ptr = 0, rd_ptr = wr_ptr = 0, count = 0, valid_out = 0, ready_in = 0. FIFO storage is not reset.
- An asserted reset mid-operation discards every buffered entry immediately and asynchronously. valid_out drops without waiting for a clock edge. The first grant after deassertion favours input 0.
- Latency: a response accepted at edge N appears on valid_out after edge N, so data is visible in cycle N+1. Minimum latency is 1 cycle. There is no combinational bypass.
- Throughput: 1 entry/cycle sustained while ready_out = 1 and count < DEPTH.
- Fairness: with all inputs continuously valid and no backpressure, grants rotate 0,1,…,N−1,0,… Worst-case wait for any input is NUM_INPUTS−1 grants.
- Handshake rule: the bench holds valid_in[i] and data_in[i] stable until accepted. The block keeps valid_out, data_out and sel_out stable until popped.

## Test plan
- Reset mid-stream: push 2 entries (DEPTH=2), assert reset asynchronously between edges → valid_out = 0 at once, count = 0. After release, input 0 and input 1 both valid → input 0 granted first.
- Round-robin: NUM_INPUTS=2, both inputs valid every cycle, ready_out=1, data_in[0]=0xA0+k, data_in[1]=0xB0+k → output alternates 0xA0, 0xB0, 0xA1, 0xB1… with sel_out 0,1,0,1. Each appears 1 cycle after acceptance.
- Backpressure/full: ready_out=0, input 1 valid with 0x11 then 0x22 → after 2 accepts ready_in = 00 and 0x33 is held off. Raise ready_out → 0x11 pops; 0x33 is accepted one cycle later; output order 0x11, 0x22, 0x33.
- Priority hold: only input 1 valid for 3 pushes, then both valid → input 0 granted next, because rr_ptr = 0 after the last grant to 1.
- Simultaneous push/pop at count=1: ready_out=1, input 0 valid every cycle → count stays 1 and one entry exits per cycle with no bubbles, values in order.
- Wrap-around: DEPTH=4, push 10 sequential values 1..10 with random ready_out → every value exits exactly once, in order, with correct sel_out. No ready_in is asserted while count = 4.
